// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, data-memory wait with timeout
module hazard_ctrl #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_num_write,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int          WW     = $clog2(WAIT_MAX + 1);
  localparam logic [31:0] TO_LIM = WAIT_MAX - 1;
  localparam logic        RUN    = 1'b0;
  localparam logic        MWAIT  = 1'b1;

  logic          state;
  logic [WW-1:0] wait_cnt;
  logic          release_q;
  logic          load_use;
  logic          freeze;
  logic          timeout;
  logic [31:0]   wait_next;

  assign load_use = ex_mem_read && (ex_num_write != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_num_write)) ||
                     (id_use_rt && (id_rt == ex_num_write)));

  // release_q masks the freeze for the single cycle after a timeout so the faulting access retires
  assign freeze    = mem_req && !mem_ready && !release_q;
  assign wait_next = {{(32-WW){1'b0}}, wait_cnt} + 32'd1;
  assign timeout   = (state == MWAIT) && freeze && (wait_next >= TO_LIM);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_exe_en    = 1'b1;
    exe_mem_en   = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    if (reset) begin
      if (freeze) begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_exe_en  = 1'b0;
        exe_mem_en = 1'b0;
        mem_wb_en  = 1'b0;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
      end else if (br_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      release_q    <= 1'b0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      release_q <= timeout;
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MWAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          if (timeout) begin
            state   <= RUN;
            mem_err <= 1'b1;
          end else if (mem_ready || !mem_req) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
      endcase
      if ((freeze || load_use) && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_num_write;
  logic        id_use_rs, id_use_rt, ex_mem_read, br_taken, mem_req, mem_ready;
  logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush, mem_err;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_en, s_if_id_en, s_id_exe_en, s_exe_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_exe_flush, s_mem_err;
  logic [2:0]  s_stall_cycles, s_flush_count;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] EN_RUN    = 7'b1111100;
  localparam logic [6:0] EN_LOAD   = 7'b0011101;
  localparam logic [6:0] EN_BRANCH = 7'b1111110;
  localparam logic [6:0] EN_FREEZE = 7'b0000000;

  hazard_ctrl dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_num_write(ex_num_write), .br_taken(br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_exe_flush(id_exe_flush), .mem_err(mem_err), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  hazard_ctrl #(.WAIT_MAX(8), .CNT_W(3)) dut_small (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_num_write(ex_num_write), .br_taken(br_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_exe_en(s_id_exe_en),
    .exe_mem_en(s_exe_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
    .id_exe_flush(s_id_exe_flush), .mem_err(s_mem_err), .stall_cycles(s_stall_cycles),
    .flush_count(s_flush_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] en_vec();
    return {25'd0, pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_flush, id_exe_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_mem_read = 0; ex_num_write = 0; br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #1;
    check("reset_en_idle", en_vec(), {25'd0, EN_RUN});
    ex_mem_read = 1; ex_num_write = 5'd8; id_rs = 5'd8; id_use_rs = 1; mem_req = 1;
    #1;
    check("reset_en_forced", en_vec(), {25'd0, EN_RUN});
    tick(); tick();
    idle();
    check("reset_mem_err", {31'd0, mem_err}, 32'd0);
    check("reset_stall", {16'd0, stall_cycles}, 32'd0);
    check("reset_flush", {16'd0, flush_count}, 32'd0);
    reset = 1'b1;
    tick();
    check("idle_en", en_vec(), {25'd0, EN_RUN});

    ex_mem_read = 1; ex_num_write = 5'd8; id_rs = 5'd8; id_use_rs = 1; #1;
    check("load_use_rs", en_vec(), {25'd0, EN_LOAD});
    tick(); idle(); #1;
    check("load_use_rs_stall", {16'd0, stall_cycles}, 32'd1);
    check("after_load_use_en", en_vec(), {25'd0, EN_RUN});

    ex_mem_read = 1; ex_num_write = 5'd17; id_rt = 5'd17; id_use_rt = 1; id_rs = 5'd3; #1;
    check("load_use_rt", en_vec(), {25'd0, EN_LOAD});
    tick(); idle();
    check("load_use_rt_stall", {16'd0, stall_cycles}, 32'd2);

    ex_mem_read = 1; ex_num_write = 5'd8; id_rs = 5'd8; id_use_rs = 0; #1;
    check("no_use_rs", en_vec(), {25'd0, EN_RUN});
    tick(); idle();
    ex_mem_read = 1; ex_num_write = 5'd0; id_rs = 5'd0; id_use_rs = 1; #1;
    check("reg0_en", en_vec(), {25'd0, EN_RUN});
    tick(); idle();
    ex_mem_read = 0; ex_num_write = 5'd8; id_rs = 5'd8; id_use_rs = 1; #1;
    check("not_load_en", en_vec(), {25'd0, EN_RUN});
    tick(); idle();
    check("no_hazard_stall", {16'd0, stall_cycles}, 32'd2);

    br_taken = 1; #1;
    check("branch_en", en_vec(), {25'd0, EN_BRANCH});
    tick(); idle();
    check("branch_flush_cnt", {16'd0, flush_count}, 32'd1);
    br_taken = 1; ex_mem_read = 1; ex_num_write = 5'd9; id_rt = 5'd9; id_use_rt = 1; #1;
    check("branch_load_use", en_vec(), {25'd0, EN_LOAD});
    tick(); idle();
    check("branch_lu_flush_cnt", {16'd0, flush_count}, 32'd1);
    check("branch_lu_stall", {16'd0, stall_cycles}, 32'd3);

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mwait_en_%0d", i), en_vec(), {25'd0, EN_FREEZE});
      tick();
    end
    mem_ready = 1; #1;
    check("mwait_release_en", en_vec(), {25'd0, EN_RUN});
    tick(); idle();
    check("mwait_state", {31'd0, dut.state}, 32'd0);
    check("mwait_stall", {16'd0, stall_cycles}, 32'd6);

    mem_req = 1; br_taken = 1; ex_mem_read = 1; ex_num_write = 5'd4; id_rs = 5'd4; id_use_rs = 1; #1;
    check("freeze_priority", en_vec(), {25'd0, EN_FREEZE});
    mem_ready = 1; tick(); idle();
    check("freeze_prio_stall", {16'd0, stall_cycles}, 32'd7);
    check("freeze_prio_flush", {16'd0, flush_count}, 32'd1);

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("to_en_%0d", i), en_vec(), {25'd0, EN_FREEZE});
      check($sformatf("to_err_%0d", i), {31'd0, mem_err}, 32'd0);
      tick();
    end
    check("to_mem_err", {31'd0, mem_err}, 32'd1);
    check("to_release_en", en_vec(), {25'd0, EN_RUN});
    check("to_state", {31'd0, dut.state}, 32'd0);
    check("to_stall", {16'd0, stall_cycles}, 32'd15);
    tick();
    check("to_refreeze_en", en_vec(), {25'd0, EN_FREEZE});
    tick(); idle(); tick();
    check("to_err_sticky", {31'd0, mem_err}, 32'd1);
    check("to_stall_after", {16'd0, stall_cycles}, 32'd16);
    check("small_stall_sat", {29'd0, s_stall_cycles}, 32'd7);
    check("small_flush", {29'd0, s_flush_count}, 32'd1);

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_wait_cnt", {28'd0, dut.wait_cnt}, 32'd4);
    reset = 1'b0; #1;
    check("rst_mid_en", en_vec(), {25'd0, EN_RUN});
    tick();
    idle(); reset = 1'b1;
    check("rst_mid_state", {31'd0, dut.state}, 32'd0);
    check("rst_mid_err", {31'd0, mem_err}, 32'd0);
    check("rst_mid_stall", {16'd0, stall_cycles}, 32'd0);
    check("rst_mid_flush", {16'd0, flush_count}, 32'd0);
    tick();
    check("rst_mid_err_after", {31'd0, mem_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 8: maximum data-memory wait cycles before timeout.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-007 ex_mem_read  input  1  instruction in EXE is a load.
REQ-008 ex_num_write  input  5  destination register of the EXE instruction.
REQ-009 br_taken  input  1  branch or jump resolved as taken in ID this cycle.
REQ-010 mem_req  input  1  MEM-stage instruction accesses data memory.
REQ-011 mem_ready  input  1  data memory completes the MEM-stage access this cycle.
REQ-012 pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  output  1 each  stage-register load enables.
REQ-013 if_id_flush, id_exe_flush  output  1 each  replace the stage-register contents with a bubble (all-zero instruction, write enables 0).
REQ-014 mem_err  output  1  sticky data-memory timeout flag.
REQ-015 stall_cycles, flush_count  output  CNT_W each  performance counters.

Function
REQ-016 The block SHALL hold a 2-state FSM: RUN, MWAIT; a wait counter of ceil(log2(WAIT_MAX+1)) bits; mem_err; and both performance counters.
REQ-017 A load-use hazard SHALL be the combinational condition ex_mem_read & ex_num_write!=0 & ((id_use_rs & id_rs==ex_num_write) | (id_use_rt & id_rt==ex_num_write)); register 0 never creates a hazard.
REQ-018 A memory freeze SHALL be the combinational condition mem_req & ~mem_ready, in either state.
REQ-019 Priority, highest first: memory freeze, load-use hazard, br_taken, none.
REQ-020 Freeze: all five enables 0, both flushes 0; the whole pipeline holds.
REQ-021 Load-use (no freeze): pc_en=0, if_id_en=0, id_exe_flush=1, exe_mem_en=1, mem_wb_en=1, if_id_flush=0; exactly one bubble is inserted per hazard cycle.
REQ-022 br_taken, no freeze or load-use: all enables 1, if_id_flush=1, id_exe_flush=0; a br_taken raised during a load-use cycle SHALL be ignored, since the branch re-evaluates once the stall releases.
REQ-023 None: all enables 1, both flushes 0.
REQ-024 FSM: RUN->MWAIT on a freeze cycle; MWAIT->RUN on the cycle mem_ready=1 or mem_req=0; the wait counter SHALL clear on entry to MWAIT and increment once per MWAIT cycle.
REQ-025 Timeout: if the wait counter reaches WAIT_MAX-1 in MWAIT with mem_ready still 0, mem_err SHALL set on that edge and the FSM SHALL return to RUN.
REQ-026 The freeze SHALL then be released for exactly one cycle (enables per REQ-021..023) so the faulting access retires; mem_err stays set until reset.
REQ-027 stall_cycles SHALL increment on every freeze or load-use cycle; flush_count SHALL increment on every cycle with if_id_flush=1; both saturate at all-ones and do not wrap.
REQ-028 All outputs other than mem_err and the counters SHALL be combinational from inputs and state with zero-cycle latency.

Reset
REQ-029 While reset=0 at a rising edge: FSM<=RUN, wait counter<=0, mem_err<=0, stall_cycles<=0, flush_count<=0.
REQ-030 During reset all enables SHALL be 1 and both flushes 0, so that datapath registers take their own reset values.
REQ-031 Reset asserted in MWAIT SHALL abort the wait with no timeout recorded.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_num_write=8, id_rs=8, id_use_rs=1 for 1 cycle -> pc_en=0, if_id_en=0, id_exe_flush=1 for that cycle; stall_cycles=1.
REQ-033 Register 0: the same as REQ-032 but ex_num_write=0 -> all enables 1, no flush, stall_cycles unchanged.
REQ-034 Branch: br_taken=1 with no hazard -> if_id_flush=1 for 1 cycle, flush_count=1; br_taken together with a load-use -> if_id_flush=0, id_exe_flush=1.
REQ-035 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> enables 0 for 3 cycles, 1 on the 4th; FSM back to RUN; stall_cycles=3.
REQ-036 Timeout: mem_req=1, mem_ready=0 held, WAIT_MAX=8 -> mem_err=1 after the 8th freeze cycle and enables 1 for one cycle; mem_err holds until reset=0.
REQ-037 Reset mid-wait: reset=0 in MWAIT at wait count 4 -> state RUN, mem_err=0, both counters 0.
